// File: rtl/index_codec_pkg.sv
// -----------------------------------------------------------------------------
// index_codec_pkg
//   Items shared by the index encoder and index decoder:
//     - slot_state_e : state of a single-entry, back-pressured output slot
//     - idx_width()  : number of bits needed to carry a bit index into a
//                      WIDTH-bit vector (never less than 1)
// -----------------------------------------------------------------------------
package index_codec_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/index_accum.sv
// -----------------------------------------------------------------------------
// index_accum
//   Frame accumulator for index_decoder. Each accepted beat ORs the one-hot
//   bit for beat_idx into the running vector; an index that does not fit in
//   WIDTH bits raises the error flag instead. The merged result (running
//   state plus the current beat) is exported so the top level can capture a
//   whole frame on the edge that accepts its last beat; that same edge clears
//   the running state for the next frame.
//
//   Optional build macro: INDEX_DECODER_DUP_DETECT_EN
//     defined   - a repeated in-range index within a frame sets frame_dup
//     undefined - no duplicate tracking, frame_dup is constant 0
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   beat_en     : a beat is accepted this cycle
//   beat_last   : the accepted beat closes the frame (clears the state)
//   beat_idx    : bit index carried by the beat
//   frame_vec   : running vector merged with the current beat's bit
//   frame_err   : running error flag merged with the current beat's error
//   frame_dup   : running duplicate flag merged with the current beat's dup
// -----------------------------------------------------------------------------
module index_accum #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat_en,
    input  logic             beat_last,
    input  logic [IDX_W-1:0] beat_idx,
    output logic [WIDTH-1:0] frame_vec,
    output logic             frame_err,
    output logic             frame_dup
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             err_acc_q, err_acc_d;
    logic [WIDTH-1:0] hit_vec;
    logic             hit_oob;

    // The shift pushes the bit off the top for any index >= WIDTH, so an
    // all-zero one-hot is exactly the out-of-range case.
    assign hit_vec   = ONE << beat_idx;
    assign hit_oob   = (hit_vec == '0);
    assign frame_vec = acc_q | hit_vec;
    assign frame_err = err_acc_q | hit_oob;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        acc_d     = acc_q;
        err_acc_d = err_acc_q;
        if (beat_en) begin
            acc_d     = beat_last ? '0   : frame_vec;
            err_acc_d = beat_last ? 1'b0 : frame_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!rst_n) begin
            acc_q     <= '0;
            err_acc_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            err_acc_q <= err_acc_d;
        end
    end

`ifdef INDEX_DECODER_DUP_DETECT_EN
    logic dup_acc_q, dup_acc_d;

    assign frame_dup = dup_acc_q | (|(acc_q & hit_vec));

    always_comb begin
        dup_acc_d = dup_acc_q;
        if (beat_en) begin
            dup_acc_d = beat_last ? 1'b0 : frame_dup;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_acc_q <= 1'b0;
        end else begin
            dup_acc_q <= dup_acc_d;
        end
    end
`else
    assign frame_dup = 1'b0;
`endif

endmodule

// File: rtl/index_decoder.sv
// -----------------------------------------------------------------------------
// index_decoder
//   Sequential inverse of the priority encoder: rebuilds a WIDTH-bit vector
//   from a stream of bit indices. Each beat sets one bit; the beat flagged
//   in_last closes the frame and the vector appears on a registered,
//   back-pressured output slot one cycle later. A single-beat frame is a plain
//   binary-to-one-hot decode.
//
//   Optional build macro: INDEX_DECODER_DUP_DETECT_EN (enables out_dup; when
//   undefined out_dup is always 0 but the port remains).
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : index beat valid
//   in_ready   : beat can be accepted (slot empty or draining this cycle)
//   in_idx     : bit index to set
//   in_last    : final beat of the frame
//   out_valid  : rebuilt vector valid
//   out_ready  : downstream accepts the vector
//   out_vec    : rebuilt vector
//   out_err    : some index in the frame was >= WIDTH
//   out_dup    : some index in the frame was repeated
// -----------------------------------------------------------------------------
module index_decoder
    import index_codec_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic             out_err,
    output logic             out_dup
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_vec_q, out_vec_d;
    logic             out_err_q, out_err_d;
    logic             out_dup_q, out_dup_d;

    logic             beat_en;
    logic             frame_load;
    logic [WIDTH-1:0] frame_vec;
    logic             frame_err;
    logic             frame_dup;

    // A full slot can still take a beat when it is draining this cycle, which
    // gives back-to-back frames without a bubble.
    assign in_ready   = (state_q == EMPTY) || out_ready;
    assign beat_en    = in_valid && in_ready;
    assign frame_load = beat_en && in_last;

    index_accum #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_en   (beat_en),
        .beat_last (in_last),
        .beat_idx  (in_idx),
        .frame_vec (frame_vec),
        .frame_err (frame_err),
        .frame_dup (frame_dup)
    );

    always_comb begin
        state_d   = state_q;
        out_vec_d = out_vec_q;
        out_err_d = out_err_q;
        out_dup_d = out_dup_q;
        unique case (state_q)
            EMPTY: begin
                if (frame_load) begin
                    state_d   = FULL;
                    out_vec_d = frame_vec;
                    out_err_d = frame_err;
                    out_dup_d = frame_dup;
                end
            end
            FULL: begin
                if (frame_load) begin
                    // Drain and reload on the same edge.
                    out_vec_d = frame_vec;
                    out_err_d = frame_err;
                    out_dup_d = frame_dup;
                end else if (out_ready) begin
                    // Clear the data too, so an empty slot always reads zero.
                    state_d   = EMPTY;
                    out_vec_d = '0;
                    out_err_d = 1'b0;
                    out_dup_d = 1'b0;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the output data register is reset along with the state so a
        // reset never leaves a stale vector on out_vec.
        if (!rst_n) begin
            state_q   <= EMPTY;
            out_vec_q <= '0;
            out_err_q <= 1'b0;
            out_dup_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_vec_q <= out_vec_d;
            out_err_q <= out_err_d;
            out_dup_q <= out_dup_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_vec   = out_vec_q;
    assign out_err   = out_err_q;
    assign out_dup   = out_dup_q;

endmodule

// File: tb/tb_index_decoder.sv
// -----------------------------------------------------------------------------
// tb_index_decoder
//   Drives two decoders in lockstep: instance a (WIDTH=8, power of two) and
//   instance b (WIDTH=6, so indices 6 and 7 are out of range). A scoreboard
//   collects the indices of each accepted beat, rebuilds the expected vector
//   per frame with plain loops, and compares it against the output slot every
//   cycle. Directed steps follow the test plan; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_index_decoder;

    typedef struct packed {
        logic [7:0] vec;
        logic       err;
        logic       dup;
    } frame_t;

`ifdef INDEX_DECODER_DUP_DETECT_EN
    localparam logic DUP_EN = 1'b1;
`else
    localparam logic DUP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_last, a_out_ready, a_in_ready, a_out_valid, a_out_err, a_out_dup;
    logic [2:0] a_in_idx;
    logic [7:0] a_out_vec;
    logic       b_in_valid, b_in_last, b_out_ready, b_in_ready, b_out_valid, b_out_err, b_out_dup;
    logic [2:0] b_in_idx;
    logic [5:0] b_out_vec;

    index_decoder #(.WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_idx(a_in_idx), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_vec(a_out_vec),
        .out_err(a_out_err), .out_dup(a_out_dup)
    );

    index_decoder #(.WIDTH(6)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(b_in_idx), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vec(b_out_vec),
        .out_err(b_out_err), .out_dup(b_out_dup)
    );

    int     checks = 0;
    int     errors = 0;
    frame_t sb_a[$], sb_b[$];
    int     cur_a[$], cur_b[$];
    logic   a_take, b_take;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected result of a frame from its index list alone.
    function automatic frame_t rebuild(input int w, input int idxs[$]);
        frame_t f;
        f = '0;
        for (int i = 0; i < idxs.size(); i++) begin
            if (idxs[i] >= w) begin
                f.err = 1'b1;
            end else begin
                for (int j = 0; j < i; j++)
                    if (idxs[j] == idxs[i]) f.dup = DUP_EN;
                f.vec[idxs[i]] = 1'b1;
            end
        end
        return f;
    endfunction

    // One clock: check outputs at the falling edge, advance the model with
    // the inputs that the coming rising edge will see, return at edge + 1.
    task automatic tick();
        frame_t ea, eb;
        @(negedge clk);
        ea = (sb_a.size() != 0) ? sb_a[0] : '0;
        eb = (sb_b.size() != 0) ? sb_b[0] : '0;
        chk("a_valid", {7'b0, a_out_valid}, {7'b0, sb_a.size() != 0});
        chk("a_ready", {7'b0, a_in_ready},  {7'b0, (sb_a.size() == 0) || a_out_ready});
        chk("a_vec",   a_out_vec,           ea.vec);
        chk("a_err",   {7'b0, a_out_err},   {7'b0, ea.err});
        chk("a_dup",   {7'b0, a_out_dup},   {7'b0, ea.dup});
        chk("b_valid", {7'b0, b_out_valid}, {7'b0, sb_b.size() != 0});
        chk("b_ready", {7'b0, b_in_ready},  {7'b0, (sb_b.size() == 0) || b_out_ready});
        chk("b_vec",   {2'b0, b_out_vec},   eb.vec);
        chk("b_err",   {7'b0, b_out_err},   {7'b0, eb.err});
        chk("b_dup",   {7'b0, b_out_dup},   {7'b0, eb.dup});

        a_take = a_in_valid && ((sb_a.size() == 0) || a_out_ready);
        b_take = b_in_valid && ((sb_b.size() == 0) || b_out_ready);
        if (sb_a.size() != 0 && a_out_ready) void'(sb_a.pop_front());
        if (sb_b.size() != 0 && b_out_ready) void'(sb_b.pop_front());
        if (a_take) begin
            cur_a.push_back(int'(a_in_idx));
            if (a_in_last) begin
                sb_a.push_back(rebuild(8, cur_a));
                cur_a.delete();
            end
        end
        if (b_take) begin
            cur_b.push_back(int'(b_in_idx));
            if (b_in_last) begin
                sb_b.push_back(rebuild(6, cur_b));
                cur_b.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input int idx, input logic last, input logic rdy);
        a_in_valid = v; a_in_idx = 3'(idx); a_in_last = last; a_out_ready = rdy;
    endtask

    task automatic set_b(input logic v, input int idx, input logic last, input logic rdy);
        b_in_valid = v; b_in_idx = 3'(idx); b_in_last = last; b_out_ready = rdy;
    endtask

    // Asynchronous reset pulse, entered and left at edge + 1.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {7'b0, a_out_valid}, 8'h00);
        chk("rst_async_vec",   a_out_vec,           8'h00);
        sb_a.delete(); sb_b.delete(); cur_a.delete(); cur_b.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(0, 0, 0, 1);
        set_b(0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_valid", {7'b0, a_out_valid}, 8'h00);
        chk("reset_vec",   a_out_vec,           8'h00);
        chk("reset_ready", {7'b0, a_in_ready},  8'h01);

        // 1: single-beat decode, one-cycle latency, drains next cycle.
        set_a(1, 5, 1, 1); tick();
        chk("t1_valid", {7'b0, a_out_valid}, 8'h01);
        chk("t1_vec",   a_out_vec,           8'h20);
        chk("t1_err",   {7'b0, a_out_err},   8'h00);
        set_a(0, 0, 0, 1); tick();
        chk("t1_drop",  {7'b0, a_out_valid}, 8'h00);

        // 2: multi-beat frame, back to back.
        set_a(1, 0, 0, 1); tick(); chk("t2_pre0", a_out_vec, 8'h00);
        set_a(1, 3, 0, 1); tick(); chk("t2_pre3", a_out_vec, 8'h00);
        set_a(1, 7, 1, 1); tick(); chk("t2_vec",  a_out_vec, 8'h89);
        set_a(0, 0, 0, 1); tick();

        // 3: back-pressure holds the slot; reload without a bubble.
        set_a(1, 1, 1, 0); tick();
        chk("t3_a_vec", a_out_vec, 8'h02);
        set_a(1, 2, 1, 0);
        repeat (4) begin
            tick();
            chk("t3_stall_ready", {7'b0, a_in_ready}, 8'h00);
            chk("t3_stall_vec",   a_out_vec,          8'h02);
        end
        a_out_ready = 1'b1; tick();
        chk("t3_b_vec",   a_out_vec,           8'h04);
        chk("t3_b_valid", {7'b0, a_out_valid}, 8'h01);
        set_a(0, 0, 0, 1); tick();

        // 4: out-of-range index on WIDTH=6, then a clean frame.
        set_b(1, 6, 0, 1); tick();
        set_b(1, 1, 1, 1); tick();
        chk("t4_vec", {2'b0, b_out_vec}, 8'h02);
        chk("t4_err", {7'b0, b_out_err}, 8'h01);
        set_b(1, 0, 1, 1); tick();
        chk("t4_vec2", {2'b0, b_out_vec}, 8'h01);
        chk("t4_err2", {7'b0, b_out_err}, 8'h00);
        set_b(0, 0, 0, 1); tick();

        // 5: reset mid-frame discards the partial accumulator.
        set_a(1, 4, 0, 1); tick();
        set_a(1, 6, 0, 1); tick();
        set_a(0, 0, 0, 1); do_reset();
        set_a(1, 2, 1, 1); tick();
        chk("t5_vec", a_out_vec, 8'h04);
        set_a(0, 0, 0, 1); tick();
        chk("t5_after", {7'b0, a_out_valid}, 8'h00);

        // Reset while the slot is full clears it without waiting for clk.
        set_a(1, 3, 1, 0); tick();
        set_a(0, 0, 0, 0); do_reset();
        set_a(0, 0, 0, 1); tick();

        // 6: repeated index.
        set_a(1, 2, 0, 1); tick();
        set_a(1, 2, 1, 1); tick();
        chk("t6_vec", a_out_vec, 8'h04);
        chk("t6_dup", {7'b0, a_out_dup}, {7'b0, DUP_EN});
        set_a(0, 0, 0, 1); tick();

        // Randomized traffic; an unaccepted beat is held unchanged.
        a_take = 1'b1; b_take = 1'b1;
        for (int n = 0; n < 500; n++) begin
            if (!a_in_valid || a_take)
                set_a(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 2) == 0), a_out_ready);
            if (!b_in_valid || b_take)
                set_b(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 2) == 0), b_out_ready);
            a_out_ready = 1'($urandom_range(0, 2) != 0);
            b_out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        set_a(0, 0, 0, 1); set_b(0, 0, 0, 1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
